// File: rtl/datapath_pkg.sv
// Shared widths and ALU opcode encoding for the datapath core.
package datapath_pkg;

   localparam int DATA_W = 64;
   localparam int REG_AW = 5;
   localparam int RAM_AW = 8;
   localparam int REG_N  = 1 << REG_AW;
   localparam int RAM_N  = 1 << RAM_AW;

   // Encodes FS[2:0]; FS[4]/FS[3] are the separate operand-invert bits.
   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_ADD   = 3'b010,
      OP_XOR   = 3'b011,
      OP_SHL   = 3'b100,
      OP_SHR   = 3'b101,
      OP_PASSB = 3'b110,
      OP_ZERO  = 3'b111
   } op_e;

endpackage

// File: rtl/datapath_core_alu64.sv
// 64-bit ALU: optional operand inversion, eight operations, {V,C,N,Z} status.
module alu64
   import datapath_pkg::*;
(
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic [4:0]        fs,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        status
);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W:0]   sum;
   logic              carry;
   logic              ovf;
   op_e               op;

   always_comb begin
      op     = op_e'(fs[2:0]);
      op_a   = fs[4] ? ~a_in : a_in;
      op_b   = fs[3] ? ~b_in : b_in;
      sum    = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, carry_in};
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (op)
         OP_AND:   result = op_a & op_b;
         OP_OR:    result = op_a | op_b;
         OP_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
            ovf    = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                     (sum[DATA_W-1] != op_a[DATA_W-1]);
         end
         OP_XOR:   result = op_a ^ op_b;
         // Only the low six bits of b form the shift amount.
         OP_SHL:   result = op_a << op_b[5:0];
         OP_SHR:   result = op_a >> op_b[5:0];
         OP_PASSB: result = op_b;
         OP_ZERO:  result = '0;
         default:  result = '0;
      endcase
      status = {ovf, carry, result[DATA_W-1], (result == '0)};
   end

endmodule

// File: rtl/datapath_core.sv
// Datapath top: 32x64 register file -> alu64 -> 256x64 data RAM with load mux.
// Define ZERO_REG_EN to make R31 a hardwired zero register.
module datapath_core
   import datapath_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] A,
   input  logic [REG_AW-1:0] B,
   input  logic              wrt,
   input  logic [REG_AW-1:0] regSel,
   input  logic [DATA_W-1:0] in,
   input  logic              muxSelect,
   input  logic [4:0]        FS,
   input  logic              CO,
   input  logic              RAMwrt,
   output logic [3:0]        SIGNAL,
   output logic [DATA_W-1:0] ALUo,
   output logic [DATA_W-1:0] RAMo
);

`ifdef ZERO_REG_EN
   localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_N - 1);
`endif

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];
   logic [DATA_W-1:0] ram_q  [RAM_N];
   logic [DATA_W-1:0] ram_d  [RAM_N];
   logic [DATA_W-1:0] bus_a;
   logic [DATA_W-1:0] bus_b;
   logic [DATA_W-1:0] reg_wdata;
   logic [RAM_AW-1:0] ram_addr;

   always_comb begin
      bus_a = regs_q[A];
      bus_b = regs_q[B];
`ifdef ZERO_REG_EN
      if (A == ZERO_REG) bus_a = '0;
      if (B == ZERO_REG) bus_b = '0;
`endif
   end

   alu64 u_alu (
      .a_in     (bus_a),
      .b_in     (bus_b),
      .fs       (FS),
      .carry_in (CO),
      .result   (ALUo),
      .status   (SIGNAL)
   );

   assign ram_addr = ALUo[RAM_AW-1:0];
   assign RAMo     = ram_q[ram_addr];

   // Load data is the pre-edge RAM content, so a same-edge RAM store is not seen.
   always_comb begin
      regs_d    = regs_q;
      reg_wdata = muxSelect ? RAMo : in;
      if (wrt) regs_d[regSel] = reg_wdata;
`ifdef ZERO_REG_EN
      regs_d[ZERO_REG] = '0;
`endif
   end

   always_comb begin
      ram_d = ram_q;
      if (RAMwrt) ram_d[ram_addr] = bus_b;
   end

   always_ff @(posedge clock) begin
      if (!reset) regs_q <= '{default: '0};
      else        regs_q <= regs_d;
   end

   // RAM has no reset and keeps accepting stores while the core is in reset.
   always_ff @(posedge clock) begin
      ram_q <= ram_d;
   end

endmodule

// File: tb/tb_datapath_core.sv
// Directed plus short random bench for datapath_core using an expected-value queue.
module tb_datapath_core;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  A, B, regSel, FS;
   logic        wrt, muxSelect, CO, RAMwrt;
   logic [63:0] in;
   logic [3:0]  SIGNAL;
   logic [63:0] ALUo, RAMo;

   typedef struct {
      string       tag;
      bit          is_ram;
      logic [63:0] value;
      logic [3:0]  sig;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [63:0] shadow [32];

   datapath_core dut (
      .clock     (clock),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .wrt       (wrt),
      .regSel    (regSel),
      .in        (in),
      .muxSelect (muxSelect),
      .FS        (FS),
      .CO        (CO),
      .RAMwrt    (RAMwrt),
      .SIGNAL    (SIGNAL),
      .ALUo      (ALUo),
      .RAMo      (RAMo)
   );

   always #5 clock = ~clock;

   function automatic void ref_alu(input logic [63:0] ra, input logic [63:0] rb,
                                   input logic [4:0] fs, input logic co,
                                   output logic [63:0] r, output logic [3:0] s);
      logic [63:0] a, b;
      logic [64:0] wide;
      logic        c, v;
      a = fs[4] ? ~ra : ra;
      b = fs[3] ? ~rb : rb;
      c = 1'b0;
      v = 1'b0;
      case (fs[2:0])
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin
            wide = {1'b0, a} + {1'b0, b} + {64'd0, co};
            r = wide[63:0];
            c = wide[64];
            v = (a[63] == b[63]) && (r[63] != a[63]);
         end
         3'd3: r = a ^ b;
         3'd4: r = a << b[5:0];
         3'd5: r = a >> b[5:0];
         3'd6: r = b;
         default: r = 64'd0;
      endcase
      s = {v, c, r[63], (r == 64'd0)};
   endfunction

   task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
      @(negedge clock);
      wrt = 1'b1; muxSelect = 1'b0; regSel = idx; in = val;
      @(posedge clock);
      #1;
      wrt = 1'b0;
      shadow[idx] = val;
   endtask

   task automatic apply_stimulus(input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] fs, input logic co);
      @(negedge clock);
      A = a; B = b; FS = fs; CO = co;
   endtask

   task automatic expect_alu(input string tag, input logic [63:0] v, input logic [3:0] s);
      exp_t e;
      e.tag = tag; e.is_ram = 1'b0; e.value = v; e.sig = s;
      sb.push_back(e);
   endtask

   task automatic expect_ram(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag; e.is_ram = 1'b1; e.value = v; e.sig = 4'd0;
      sb.push_back(e);
   endtask

   task automatic check_output();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (e.is_ram) begin
            assert (RAMo === e.value) else begin
               bad++;
               $error("[TB] FAIL %s: RAMo=%h expected %h", e.tag, RAMo, e.value);
            end
         end else begin
            assert (ALUo === e.value && SIGNAL === e.sig) else begin
               bad++;
               $error("[TB] FAIL %s: ALUo=%h SIGNAL=%b expected ALUo=%h SIGNAL=%b",
                      e.tag, ALUo, SIGNAL, e.value, e.sig);
            end
         end
      end
   endtask

   task automatic clock_controls(input logic ram_we, input logic reg_we,
                                 input logic sel, input logic [4:0] idx);
      @(negedge clock);
      RAMwrt = ram_we; wrt = reg_we; muxSelect = sel; regSel = idx;
      @(posedge clock);
      #1;
      RAMwrt = 1'b0; wrt = 1'b0; muxSelect = 1'b0;
   endtask

   initial begin
      logic [63:0] er;
      logic [3:0]  es;
      logic [4:0]  ra, rb, rf;
      logic        rc;

      reset = 1'b0; A = '0; B = '0; regSel = 5'd9; FS = '0; CO = 1'b0;
      wrt = 1'b1; muxSelect = 1'b0; RAMwrt = 1'b0; in = 64'hAA;
      for (int i = 0; i < 32; i++) shadow[i] = 64'd0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1; wrt = 1'b0;
      $display("[TB] reset released");

      apply_stimulus(5'd3, 5'd7, 5'b00110, 1'b0);
      expect_alu("reset_pass_b", 64'd0, 4'b0001);
      check_output();
      apply_stimulus(5'd0, 5'd9, 5'b00110, 1'b0);
      expect_alu("reset_overrides_wrt", 64'd0, 4'b0001);
      check_output();

      write_reg(5'd1, 64'd7364);
      apply_stimulus(5'd1, 5'd1, 5'b00010, 1'b0);
      expect_alu("write_read_add", 64'd14728, 4'b0000);
      check_output();

      write_reg(5'd2, 64'h7FFF_FFFF_FFFF_FFFF);
      write_reg(5'd3, 64'd1);
      write_reg(5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
      apply_stimulus(5'd2, 5'd3, 5'b00010, 1'b0);
      expect_alu("add_overflow", 64'h8000_0000_0000_0000, 4'b1010);
      check_output();
      apply_stimulus(5'd4, 5'd3, 5'b00010, 1'b0);
      expect_alu("add_carry_zero", 64'd0, 4'b0101);
      check_output();

      write_reg(5'd5, 64'h1234);
      apply_stimulus(5'd0, 5'd5, 5'b00110, 1'b0);
      expect_alu("ram_addr_pass_b", 64'h1234, 4'b0000);
      check_output();
      clock_controls(1'b1, 1'b0, 1'b0, 5'd0);
      expect_ram("ram_store", 64'h1234);
      check_output();
      clock_controls(1'b0, 1'b1, 1'b1, 5'd6);
      apply_stimulus(5'd0, 5'd6, 5'b00110, 1'b0);
      expect_alu("load_r6", 64'h1234, 4'b0000);
      expect_ram("load_r6_ram", 64'h1234);
      check_output();

      write_reg(5'd7, 64'h5634);
      apply_stimulus(5'd0, 5'd7, 5'b00110, 1'b0);
      clock_controls(1'b1, 1'b1, 1'b1, 5'd8);
      apply_stimulus(5'd0, 5'd8, 5'b00110, 1'b0);
      expect_alu("simul_load_old", 64'h1234, 4'b0000);
      expect_ram("simul_ram_new", 64'h5634);
      check_output();

      write_reg(5'd1, 64'd10);
      write_reg(5'd2, 64'd3);
      apply_stimulus(5'd1, 5'd2, 5'b01010, 1'b1);
      expect_alu("subtract", 64'd7, 4'b0100);
      check_output();
      apply_stimulus(5'd1, 5'd2, 5'b00100, 1'b0);
      expect_alu("shl_3", 64'd80, 4'b0000);
      check_output();
      apply_stimulus(5'd1, 5'd2, 5'b00101, 1'b0);
      expect_alu("shr_3", 64'd1, 4'b0000);
      check_output();

      write_reg(5'd12, 64'd63);
      write_reg(5'd13, 64'd1);
      write_reg(5'd14, 64'd67);
      write_reg(5'd15, 64'h8000_0000_0000_0000);
      apply_stimulus(5'd13, 5'd12, 5'b00100, 1'b0);
      expect_alu("shl_63", 64'h8000_0000_0000_0000, 4'b0010);
      check_output();
      apply_stimulus(5'd15, 5'd12, 5'b00101, 1'b0);
      expect_alu("shr_63", 64'd1, 4'b0000);
      check_output();
      apply_stimulus(5'd13, 5'd14, 5'b00100, 1'b0);
      expect_alu("shl_amt_masked", 64'd8, 4'b0000);
      check_output();

      apply_stimulus(5'd1, 5'd1, 5'b00011, 1'b0);
      expect_alu("xor_self", 64'd0, 4'b0001);
      check_output();
      apply_stimulus(5'd4, 5'd4, 5'b00111, 1'b1);
      expect_alu("op_zero", 64'd0, 4'b0001);
      check_output();
      apply_stimulus(5'd4, 5'd1, 5'b10001, 1'b0);
      expect_alu("or_inv_a", 64'd10, 4'b0000);
      check_output();
      apply_stimulus(5'd4, 5'd2, 5'b01000, 1'b0);
      expect_alu("and_inv_b", 64'hFFFF_FFFF_FFFF_FFFC, 4'b0010);
      check_output();
      apply_stimulus(5'd0, 5'd0, 5'b01110, 1'b0);
      expect_alu("pass_not_b", 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
      check_output();

      @(negedge clock);
      A = 5'd1; B = 5'd1; FS = 5'b00010; CO = 1'b0;
      wrt = 1'b1; muxSelect = 1'b0; regSel = 5'd1; in = 64'd100;
      expect_alu("collision_old", 64'd20, 4'b0000);
      check_output();
      @(posedge clock);
      #1;
      wrt = 1'b0;
      shadow[1] = 64'd100;
      expect_alu("collision_new", 64'd200, 4'b0000);
      check_output();

      write_reg(5'd10, 64'h1_0000_0099);
      apply_stimulus(5'd0, 5'd10, 5'b00110, 1'b0);
      @(negedge clock);
      reset = 1'b0; RAMwrt = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b1; RAMwrt = 1'b0;
      for (int i = 0; i < 32; i++) shadow[i] = 64'd0;
      apply_stimulus(5'd10, 5'd10, 5'b00110, 1'b0);
      expect_alu("mid_reset_clears", 64'd0, 4'b0001);
      check_output();
      write_reg(5'd11, 64'h99);
      apply_stimulus(5'd0, 5'd11, 5'b00110, 1'b0);
      expect_alu("wrap_addr", 64'h99, 4'b0000);
      expect_ram("ram_write_in_reset", 64'h1_0000_0099);
      check_output();

      write_reg(5'd31, 64'hFF);
      apply_stimulus(5'd31, 5'd0, 5'b00001, 1'b0);
`ifdef ZERO_REG_EN
      expect_alu("r31_read", 64'd0, 4'b0001);
`else
      expect_alu("r31_read", 64'hFF, 4'b0000);
`endif
      check_output();

      for (int i = 20; i < 24; i++)
         write_reg(5'(i), {$urandom(), $urandom()});
      write_reg(5'd24, 64'h7FFF_FFFF_0000_0000);
      for (int n = 0; n < 16; n++) begin
         ra = 5'(20 + $urandom_range(0, 4));
         rb = 5'(20 + $urandom_range(0, 4));
         rf = 5'($urandom_range(0, 31));
         rc = 1'($urandom_range(0, 1));
         apply_stimulus(ra, rb, rf, rc);
         ref_alu(shadow[ra], shadow[rb], rf, rc, er, es);
         expect_alu($sformatf("rand_%0d_fs%b", n, rf), er, es);
         check_output();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: sim time exceeded limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
